tea_ctrl: RTL

TEA_CTRL -- requirements
Module: tea_ctrl

---
 rtl/tea_ctrl.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/tea_ctrl.sv
// -----------------------------------------------------------------------------
// tea_ctrl
//
// Sequencer that drives a register-mapped TEA core for one block at a time.
// A request (block, 128-bit key, mode) is captured on the valid/ready
// handshake. The controller then:
//   1. pulses the core reset for one cycle,
//   2. writes the block, key low word, key high word and control word,
//   3. waits (bounded by TIMEOUT) for the core done flag,
//   4. reads the result register,
//   5. presents the result on a valid/ready output handshake.
// A core that never finishes parks the controller in a terminal error state
// (sticky o_err, core held in reset) that only i_rstn can clear.
//
// Core register map: 0 = data, 1 = key low, 2 = key high,
//                    3 = control (1 = encrypt, 2 = decrypt), 4 = result.
//
// Ports
//   i_clk, i_rstn          clock, asynchronous active-low reset
//   i_valid / o_in_ready   request handshake
//   i_block, i_key, i_mode request payload (mode 0 = encrypt, 1 = decrypt)
//   o_valid / i_out_ready  result handshake
//   o_result               result block, stable while o_valid is high
//   o_err                  sticky core-timeout flag
//   o_tea_*                core reset, register address, write data, write enable
//   i_tea_data, i_tea_ready core read data and done flag
//
// All outputs are registered: each *_d output value is decoded from the
// next state so that the registered output lines up with the state it
// belongs to, without an extra cycle of lag.
// -----------------------------------------------------------------------------
module tea_ctrl #(
  parameter int WORD_SIZE = 64,
  parameter int TIMEOUT   = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_valid,
  output logic                   o_in_ready,
  input  logic [WORD_SIZE-1:0]   i_block,
  input  logic [2*WORD_SIZE-1:0] i_key,
  input  logic                   i_mode,
  output logic                   o_valid,
  input  logic                   i_out_ready,
  output logic [WORD_SIZE-1:0]   o_result,
  output logic                   o_err,
  output logic                   o_tea_rstn,
  output logic [2:0]             o_tea_addr,
  output logic [WORD_SIZE-1:0]   o_tea_data,
  output logic                   o_tea_we,
  input  logic [WORD_SIZE-1:0]   i_tea_data,
  input  logic                   i_tea_ready
);

  localparam int                CNT_W       = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(TIMEOUT);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_KEY_LO = 3'd1;
  localparam logic [2:0] ADDR_KEY_HI = 3'd2;
  localparam logic [2:0] ADDR_CTRL   = 3'd3;
  localparam logic [2:0] ADDR_RESULT = 3'd4;

  typedef enum logic [3:0] {
    IDLE,
    CRST,
    WDAT,
    WKLO,
    WKHI,
    WCTL,
    WAIT,
    RADR,
    RSMP,
    OUT,
    ERR
  } state_e;

  // State and captured request
  state_e                 state_q,    state_d;
  logic [WORD_SIZE-1:0]   blk_q,      blk_d;
  logic [2*WORD_SIZE-1:0] key_q,      key_d;
  logic                   mode_q,     mode_d;
  logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;

  // Registered outputs
  logic                   in_ready_q, in_ready_d;
  logic                   valid_q,    valid_d;
  logic [WORD_SIZE-1:0]   result_q,   result_d;
  logic                   err_q,      err_d;
  logic                   tea_rstn_q, tea_rstn_d;
  logic [2:0]             tea_addr_q, tea_addr_d;
  logic [WORD_SIZE-1:0]   tea_data_q, tea_data_d;
  logic                   tea_we_q,   tea_we_d;

  // ---------------------------------------------------------------------------
  // Next-state and next-output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // through the case statements can leave one unassigned and infer a latch.
    state_d    = state_q;
    blk_d      = blk_q;
    key_d      = key_q;
    mode_d     = mode_q;
    wait_cnt_d = wait_cnt_q;
    result_d   = result_q;

    case (state_q)
      IDLE: begin
        // in_ready_q rather than the state alone: it stays low for the first
        // cycle after reset release, so nothing is accepted before it rises.
        if (i_valid && in_ready_q) begin
          state_d = CRST;
          blk_d   = i_block;
          key_d   = i_key;
          mode_d  = i_mode;
        end
      end
      CRST: state_d = WDAT;
      WDAT: state_d = WKLO;
      WKLO: state_d = WKHI;
      WKHI: state_d = WCTL;
      WCTL: begin
        state_d    = WAIT;
        wait_cnt_d = '0;
      end
      WAIT: begin
        // A done flag on the last allowed cycle still wins over the timeout.
        if (i_tea_ready) begin
          state_d = RADR;
        end else begin
          if (wait_cnt_q != TIMEOUT_CNT) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
          if (wait_cnt_d == TIMEOUT_CNT) begin
            state_d = ERR;
          end
        end
      end
      RADR: state_d = RSMP;
      RSMP: begin
        // Address 4 has been on the bus since RADR, so the read data is settled.
        result_d = i_tea_data;
        state_d  = OUT;
      end
      OUT: begin
        if (i_out_ready) begin
          state_d = IDLE;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they are valid in that state.
    in_ready_d = (state_d == IDLE);
    valid_d    = (state_d == OUT);
    err_d      = err_q || (state_d == ERR);
    tea_rstn_d = !(state_d inside {CRST, ERR});

    tea_we_d   = 1'b0;
    tea_addr_d = ADDR_DATA;
    tea_data_d = '0;
    case (state_d)
      WDAT: begin
        tea_we_d   = 1'b1;
        tea_addr_d = ADDR_DATA;
        tea_data_d = blk_q;
      end
      WKLO: begin
        tea_we_d   = 1'b1;
        tea_addr_d = ADDR_KEY_LO;
        tea_data_d = key_q[WORD_SIZE-1:0];
      end
      WKHI: begin
        tea_we_d   = 1'b1;
        tea_addr_d = ADDR_KEY_HI;
        tea_data_d = key_q[2*WORD_SIZE-1:WORD_SIZE];
      end
      WCTL: begin
        tea_we_d   = 1'b1;
        tea_addr_d = ADDR_CTRL;
        tea_data_d = mode_q ? WORD_SIZE'(2) : WORD_SIZE'(1);
      end
      RADR, RSMP: begin
        tea_addr_d = ADDR_RESULT;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order; the decode above
  // uses blocking assignments because it is combinational.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= IDLE;
      blk_q      <= '0;
      key_q      <= '0;
      mode_q     <= 1'b0;
      wait_cnt_q <= '0;
      in_ready_q <= 1'b0;
      valid_q    <= 1'b0;
      result_q   <= '0;
      err_q      <= 1'b0;
      tea_rstn_q <= 1'b0;
      tea_addr_q <= ADDR_DATA;
      tea_data_q <= '0;
      tea_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      key_q      <= key_d;
      mode_q     <= mode_d;
      wait_cnt_q <= wait_cnt_d;
      in_ready_q <= in_ready_d;
      valid_q    <= valid_d;
      result_q   <= result_d;
      err_q      <= err_d;
      tea_rstn_q <= tea_rstn_d;
      tea_addr_q <= tea_addr_d;
      tea_data_q <= tea_data_d;
      tea_we_q   <= tea_we_d;
    end
  end

  assign o_in_ready = in_ready_q;
  assign o_valid    = valid_q;
  assign o_result   = result_q;
  assign o_err      = err_q;
  assign o_tea_rstn = tea_rstn_q;
  assign o_tea_addr = tea_addr_q;
  assign o_tea_data = tea_data_q;
  assign o_tea_we   = tea_we_q;

endmodule
